// File: rtl/arbitro_mem_datos.sv
// Load/store arbiter between two issue lanes and a dual-port data memory.
// Same-address pairs involving a store are serialized lane 1 first; others issue in parallel.
module arbitro_mem_datos #(
  parameter logic [31:0] ADDR_BASE = 32'h10000000,
  parameter int unsigned N_WORDS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_1,
  input  logic        req_valid_2,
  input  logic        req_wr_1,
  input  logic        req_wr_2,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_addr_2,
  input  logic [31:0] req_wdata_1,
  input  logic [31:0] req_wdata_2,
  output logic        ready,
  output logic        done_1,
  output logic        done_2,
  output logic        err_1,
  output logic        err_2,
  output logic [31:0] rdata_1,
  output logic [31:0] rdata_2,
  output logic        Mem_rd_1,
  output logic        Mem_wr_1,
  output logic        Mem_rd_2,
  output logic        Mem_wr_2,
  output logic [31:0] Dir_Mem_1,
  output logic [31:0] Dir_Mem_2,
  output logic [31:0] Dato_Mem_in_1,
  output logic [31:0] Dato_Mem_in_2,
  input  logic [31:0] Dato_Mem_out_1,
  input  logic [31:0] Dato_Mem_out_2
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_AB = 3'd1,
    ISSUE_A  = 3'd2,
    ISSUE_B  = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic        in_vld   [2];
  logic        in_wr    [2];
  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic [31:0] mem_out  [2];

  logic        vld_q    [2];
  logic        wr_q     [2];
  logic [31:0] addr_q   [2];
  logic [31:0] wdata_q  [2];
  logic [31:0] cap_q    [2];
  logic [31:0] rdata_q  [2];
  logic        err_q    [2];
  logic        done_q   [2];

  logic        inr      [2];
  logic        port_act [2];
  logic        drive    [2];
  logic [31:0] rd_val   [2];
  logic [31:0] resp_val [2];
  logic        rd_n     [2];
  logic        wr_n     [2];
  logic [31:0] dir      [2];
  logic [31:0] dato_in  [2];

  logic conflict;
  logic accept;
  logic going_resp;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (off < 32'(N_WORDS));
  endfunction

  assign in_vld[0]   = req_valid_1;
  assign in_vld[1]   = req_valid_2;
  assign in_wr[0]    = req_wr_1;
  assign in_wr[1]    = req_wr_2;
  assign in_addr[0]  = req_addr_1;
  assign in_addr[1]  = req_addr_2;
  assign in_wdata[0] = req_wdata_1;
  assign in_wdata[1] = req_wdata_2;
  assign mem_out[0]  = Dato_Mem_out_1;
  assign mem_out[1]  = Dato_Mem_out_2;

  // An out-of-range lane is never strobed, so it cannot create an ordering hazard.
  assign conflict = req_valid_1 & req_valid_2 & (req_addr_1 == req_addr_2)
                  & (req_wr_1 | req_wr_2) & in_range(req_addr_1);

  assign ready  = ~rst & (state_q == IDLE);
  assign accept = (state_q == IDLE) & (req_valid_1 | req_valid_2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    port_act[0] = 1'b0;
    port_act[1] = 1'b0;
    going_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_1 || req_valid_2) begin
          state_d = conflict ? ISSUE_A : ISSUE_AB;
        end
      end
      ISSUE_AB: begin
        port_act[0] = 1'b1;
        port_act[1] = 1'b1;
        going_resp  = 1'b1;
        state_d     = RESP;
      end
      ISSUE_A: begin
        port_act[0] = 1'b1;
        state_d     = ISSUE_B;
      end
      ISSUE_B: begin
        port_act[1] = 1'b1;
        going_resp  = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign inr[gi]     = in_range(addr_q[gi]);
    assign drive[gi]   = port_act[gi] & vld_q[gi] & inr[gi];
    assign rd_n[gi]    = ~(drive[gi] & ~wr_q[gi]);
    assign wr_n[gi]    = ~(drive[gi] & wr_q[gi]);
    assign dir[gi]     = drive[gi] ? addr_q[gi]  : 32'd0;
    assign dato_in[gi] = drive[gi] ? wdata_q[gi] : 32'd0;
    assign rd_val[gi]  = (drive[gi] && !wr_q[gi]) ? mem_out[gi] : 32'd0;
    // Lane 1 of a serialized pair was read a cycle earlier and parked in cap_q.
    assign resp_val[gi] = port_act[gi] ? rd_val[gi] : cap_q[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[gi]   <= 1'b0;
        wr_q[gi]    <= 1'b0;
        addr_q[gi]  <= 32'd0;
        wdata_q[gi] <= 32'd0;
        cap_q[gi]   <= 32'd0;
        rdata_q[gi] <= 32'd0;
        err_q[gi]   <= 1'b0;
        done_q[gi]  <= 1'b0;
      end else begin
        if (accept) begin
          vld_q[gi]   <= in_vld[gi];
          wr_q[gi]    <= in_wr[gi];
          addr_q[gi]  <= in_addr[gi];
          wdata_q[gi] <= in_wdata[gi];
        end
        if (port_act[gi]) begin
          cap_q[gi] <= rd_val[gi];
        end
        done_q[gi] <= going_resp & vld_q[gi];
        if (going_resp && vld_q[gi]) begin
          rdata_q[gi] <= resp_val[gi];
          err_q[gi]   <= ~inr[gi];
        end
      end
    end
  end

  assign done_1        = done_q[0];
  assign done_2        = done_q[1];
  assign err_1         = err_q[0];
  assign err_2         = err_q[1];
  assign rdata_1       = rdata_q[0];
  assign rdata_2       = rdata_q[1];
  assign Mem_rd_1      = rd_n[0];
  assign Mem_wr_1      = wr_n[0];
  assign Mem_rd_2      = rd_n[1];
  assign Mem_wr_2      = wr_n[1];
  assign Dir_Mem_1     = dir[0];
  assign Dir_Mem_2     = dir[1];
  assign Dato_Mem_in_1 = dato_in[0];
  assign Dato_Mem_in_2 = dato_in[1];

endmodule
